sm4_round_ctrl: RTL and testbench
=================================

SM4_ROUND_CTRL -- requirements
Module: sm4_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 32, number of round-function passes per block.
REQ-002 Parameter MODE_DEC, default 1'b1, i_mode encoding for decryption; 1'b0 is encryption.
REQ-003 Clock and reset: one clock, i_clk; reset i_rst is synchronous and active-high.
REQ-004 i_clk  in  1  rising-edge clock.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_key_ready  in  1  round-key RAM holds a complete expanded key.
REQ-007 i_valid  in  1  input block offered.
REQ-008 o_ready  out  1  controller accepts a block this cycle.
REQ-009 i_mode  in  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-010 i_data  in  128  plaintext/ciphertext block (X0..X3, X0 in [127:96]).
REQ-011 o_valid  out  1  result block available.
REQ-012 i_ready  in  1  downstream accepts the result.
REQ-013 o_data  out  128  result block.
REQ-014 o_busy  out  1  high whenever the state is not IDLE.
REQ-015 o_rf_data  out  128  state word presented to the round function.
REQ-016 o_rf_valid  out  1  single-cycle issue strobe to the round function.
REQ-017 o_rk_rd  out  1  round-key RAM read enable, coincident with o_rf_valid.
REQ-018 o_rk_addr  out  5  round-key index; RAM returns data after one cycle, aligned with the round function's rk sampling.
REQ-019 i_rf_valid  in  1  round function result strobe.
REQ-020 i_rf_next_data  in  128  round-function updated state {X(i+1..i+4)}.

Function
REQ-021 States: IDLE, ISSUE, WAIT, DONE.
REQ-022 IDLE: o_ready = i_key_ready; on i_valid && o_ready, latch i_data into the state register and i_mode, clear the round counter, and go to ISSUE.
REQ-023 ISSUE (exactly one cycle): assert o_rf_valid and o_rk_rd; drive o_rf_data from the state register; go to WAIT.
REQ-024 Key address is the round counter k when encrypting and NUM_ROUNDS-1-k when decrypting.
REQ-025 WAIT: on i_rf_valid, capture i_rf_next_data; if k = NUM_ROUNDS-1, go to DONE, otherwise increment k and go to ISSUE.
REQ-026 i_rf_valid outside WAIT is ignored and leaves the state register unchanged.
REQ-027 Entering DONE loads o_data with the word-reversed final state: {S[31:0], S[63:32], S[95:64], S[127:96]}.
REQ-028 DONE: o_valid high, o_data stable, o_ready low; on i_ready, go to IDLE; a new accept is possible no earlier than the following cycle.
REQ-029 Issue is event-driven; there is no timeout. With a 5-cycle round function, accept at cycle T gives issues at T+1+6k and o_valid at T+193.
REQ-030 The round counter is 5 bits and never wraps within a block.
REQ-031 A drop of i_key_ready mid-block has no effect; it gates acceptance only.
REQ-032 Only one block is in flight at a time.

Reset
REQ-033 While i_rst is high, at the clock edge the state becomes IDLE and k = 0.
REQ-034 Reset values: o_valid = 0, o_rf_valid = 0, o_rk_rd = 0, o_rk_addr = 0, o_data = 0, o_rf_data = 0, o_busy = 0.
REQ-035 Reset mid-block abandons the block with no output; a result strobe arriving after reset is ignored per REQ-026.
REQ-036 o_ready is 0 during reset and equals i_key_ready in the first cycle after reset.

Structure
REQ-037 Shared package sm4_pkg holds NUM_ROUNDS, the mode encodings and the state enumeration.
REQ-038 No sub-module is required; the round function and key RAM are siblings instantiated in sm4_core.

Verification
REQ-039 Encrypt: key 0123456789abcdeffedcba9876543210, data of the same value, real round function and key RAM -> o_data = 681edf34d206965e86b3e94f536e4246 at T+193.
REQ-040 Decrypt with the same key, data 681edf34d206965e86b3e94f536e4246 -> o_data = 0123456789abcdeffedcba9876543210; o_rk_addr sequence is 31, 30, ..., 0.
REQ-041 Hold i_ready low 10 cycles in DONE -> o_valid and o_data stable, o_ready = 0, no o_rf_valid pulses.
REQ-042 i_key_ready = 0 with i_valid = 1 -> no accept, o_busy = 0; raising i_key_ready -> accept on that cycle.
REQ-043 Assert i_rst at round 12, then inject a stray i_rf_valid -> IDLE, all outputs at reset values, next block encrypts correctly.
REQ-044 Back-to-back blocks with i_ready tied high -> second accept exactly one cycle after first o_valid, 32 o_rf_valid pulses per block.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: round count, mode encodings and the round
// controller state enumeration.
package sm4_pkg;

    localparam int   SM4_NUM_ROUNDS = 32;
    localparam logic SM4_MODE_ENC   = 1'b0;
    localparam logic SM4_MODE_DEC   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } sm4_state_t;

endpackage

// File: rtl/sm4_round_ctrl.sv
// SM4 round controller: sequences one block through an external round
// function and round-key RAM, one round at a time, then presents the result.
module sm4_round_ctrl
    import sm4_pkg::*;
#(
    parameter int   NUM_ROUNDS = SM4_NUM_ROUNDS,
    parameter logic MODE_DEC   = SM4_MODE_DEC
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_key_ready,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_mode,
    input  logic [127:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_busy,
    output logic [127:0] o_rf_data,
    output logic         o_rf_valid,
    output logic         o_rk_rd,
    output logic [4:0]   o_rk_addr,
    input  logic         i_rf_valid,
    input  logic [127:0] i_rf_next_data
);

    localparam logic [4:0] LAST_K = 5'(NUM_ROUNDS - 1);

    sm4_state_t   state;
    sm4_state_t   state_nxt;
    logic [4:0]   round_k;
    logic         mode_dec;
    logic [127:0] state_word;
    logic [127:0] result_word;
    logic         accept;
    logic         rf_capture;

    // The cipher output is the last four state words in reverse order.
    function automatic logic [127:0] word_reverse(input logic [127:0] s);
        return {s[31:0], s[63:32], s[95:64], s[127:96]};
    endfunction

    assign accept     = (state == ST_IDLE) && !i_rst && i_valid && i_key_ready;
    assign rf_capture = (state == ST_WAIT) && i_rf_valid;

    assign o_busy    = (state != ST_IDLE);
    assign o_rf_data = state_word;
    assign o_data    = result_word;
    // Decryption walks the same key schedule backwards.
    assign o_rk_addr = mode_dec ? (LAST_K - round_k) : round_k;

    always_comb begin
        state_nxt  = state;
        o_ready    = 1'b0;
        o_rf_valid = 1'b0;
        o_rk_rd    = 1'b0;
        o_valid    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                o_ready = i_key_ready && !i_rst;
                if (accept) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_rf_valid = 1'b1;
                o_rk_rd    = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_rf_valid) begin
                    state_nxt = (round_k == LAST_K) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            round_k     <= '0;
            mode_dec    <= 1'b0;
            state_word  <= '0;
            result_word <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                state_word <= i_data;
                mode_dec   <= (i_mode == MODE_DEC);
                round_k    <= '0;
            end
            if (rf_capture) begin
                state_word <= i_rf_next_data;
                if (round_k == LAST_K) begin
                    result_word <= word_reverse(i_rf_next_data);
                end else begin
                    round_k <= round_k + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Bench for sm4_round_ctrl: emulates a 5-cycle round function plus key RAM
// and compares results against a textbook SM4 reference model.
module tb_sm4_round_ctrl;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_key_ready;
    logic         i_valid;
    logic         o_ready;
    logic         i_mode;
    logic [127:0] i_data;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_data;
    logic         o_busy;
    logic [127:0] o_rf_data;
    logic         o_rf_valid;
    logic         o_rk_rd;
    logic [4:0]   o_rk_addr;
    logic         i_rf_valid;
    logic [127:0] i_rf_next_data;

    always #5 i_clk = ~i_clk;

    sm4_round_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_key_ready    (i_key_ready),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_mode         (i_mode),
        .i_data         (i_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_busy         (o_busy),
        .o_rf_data      (o_rf_data),
        .o_rf_valid     (o_rf_valid),
        .o_rk_rd        (o_rk_rd),
        .o_rk_addr      (o_rk_addr),
        .i_rf_valid     (i_rf_valid),
        .i_rf_next_data (i_rf_next_data)
    );

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };
    localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic [31:0]  rk [32];
    int           passed = 0;
    int           failed = 0;
    int           total  = 0;
    int           pulse_cnt = 0;
    int           addr_base = 0;
    logic [4:0]   addr_log [$];
    logic [5:0]   rf_v = '0;
    logic [127:0] rf_d [6] = '{default: '0};
    logic         stray_v = 1'b0;
    logic [127:0] stray_d = '0;

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] a);
        logic [31:0] b;
        int idx;
        for (int j = 0; j < 4; j++) begin
            idx = int'(a[8*j +: 8]);
            b[8*j +: 8] = SBOX[2047 - 8*idx -: 8];
        end
        return b;
    endfunction

    function automatic logic [31:0] lin_t(input logic [31:0] a);
        logic [31:0] b;
        b = tau(a);
        return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
    endfunction

    // One round as the sibling round-function block would compute it.
    function automatic logic [127:0] rf_step(input logic [127:0] s, input logic [31:0] k);
        return {s[95:0], s[127:96] ^ lin_t(s[95:64] ^ s[63:32] ^ s[31:0] ^ k)};
    endfunction

    // Whole-block SM4: X(i+4) = X(i) ^ T(X(i+1)^X(i+2)^X(i+3)^rk), output reversed.
    function automatic logic [127:0] sm4_ref(input logic [127:0] din, input logic dec);
        logic [31:0] x [36];
        logic [31:0] r;
        x[0] = din[127:96]; x[1] = din[95:64]; x[2] = din[63:32]; x[3] = din[31:0];
        for (int i = 0; i < 32; i++) begin
            r = dec ? rk[31 - i] : rk[i];
            x[i + 4] = x[i] ^ lin_t(x[i + 1] ^ x[i + 2] ^ x[i + 3] ^ r);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    task automatic set_key(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] ck;
        logic [31:0] t;
        int c;
        k[0] = mk[127:96] ^ 32'ha3b1bac6;
        k[1] = mk[95:64]  ^ 32'h56aa3350;
        k[2] = mk[63:32]  ^ 32'h677d9197;
        k[3] = mk[31:0]   ^ 32'hb27022dc;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                c = ((4 * i + j) * 7) % 256;
                ck[31 - 8*j -: 8] = c[7:0];
            end
            t = tau(k[i + 1] ^ k[i + 2] ^ k[i + 3] ^ ck);
            k[i + 4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
            rk[i] = k[i + 4];
        end
    endtask

    // Round function + key RAM emulation: result strobe 5 cycles after issue.
    always @(negedge i_clk) begin
        rf_v    <= {rf_v[4:0], o_rf_valid};
        rf_d[0] <= o_rf_valid ? rf_step(o_rf_data, rk[o_rk_addr]) : 128'd0;
        for (int i = 1; i < 6; i++) rf_d[i] <= rf_d[i - 1];
        if (o_rf_valid) begin
            pulse_cnt <= pulse_cnt + 1;
            addr_log.push_back(o_rk_addr);
        end
    end

    assign i_rf_valid     = rf_v[5] | stray_v;
    assign i_rf_next_data = stray_v ? stray_d : rf_d[5];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_addrs(input string tag, input logic dec);
        logic ok;
        logic [4:0] want;
        ok = (addr_log.size() >= addr_base + 32);
        for (int i = 0; i < 32 && ok; i++) begin
            want = dec ? 5'(31 - i) : 5'(i);
            if (addr_log[addr_base + i] !== want) ok = 1'b0;
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"}, {o_valid, o_rf_valid, o_rk_rd, o_busy}, 4'b0000);
        check({tag, "_addr"}, o_rk_addr, 5'd0);
        check({tag, "_data"}, o_data, 128'd0);
        check({tag, "_rfdata"}, o_rf_data, 128'd0);
    endtask

    task automatic do_block(input logic [127:0] din, input logic dec, input int hold,
                            input logic drop_key, output logic [127:0] dout, output int lat,
                            output int wait_n, output int pulses, output logic stable);
        int p0;
        i_valid = 1'b1;
        i_data  = din;
        i_mode  = dec;
        #1;
        wait_n = 0;
        while (!o_ready && wait_n < 100) begin
            @(negedge i_clk);
            #1;
            wait_n++;
        end
        p0 = pulse_cnt;
        addr_base = addr_log.size();
        @(negedge i_clk);
        i_valid = 1'b0;
        if (drop_key) i_key_ready = 1'b0;
        lat = 1;
        while (!o_valid && lat < 400) begin
            @(negedge i_clk);
            lat++;
        end
        dout = o_data;
        stable = 1'b1;
        if (hold > 0) begin
            i_ready = 1'b0;
            for (int c = 0; c < hold; c++) begin
                @(negedge i_clk);
                if (!(o_valid === 1'b1 && o_data === dout && o_ready === 1'b0 && o_rf_valid === 1'b0))
                    stable = 1'b0;
            end
            i_ready = 1'b1;
        end
        @(negedge i_clk);
        i_key_ready = 1'b1;
        pulses = pulse_cnt - p0;
    endtask

    initial begin
        logic [127:0] din;
        logic [127:0] dout;
        logic [127:0] dout2;
        logic         dec;
        logic         stable;
        int           lat;
        int           wait_n;
        int           pulses;
        int           guard;
        int           p0;

        i_rst = 1'b1; i_key_ready = 1'b1; i_valid = 1'b0; i_mode = 1'b0;
        i_data = '0; i_ready = 1'b1;
        set_key(KAT_KEY);

        // Reset values and o_ready gating during reset
        repeat (3) @(negedge i_clk);
        check("rst_o_ready", o_ready, 1'b0);
        check_reset_outs("rst");
        i_rst = 1'b0;
        #1;
        check("post_rst_o_ready", o_ready, 1'b1);

        // Key not ready: offered block must be refused
        @(negedge i_clk);
        i_key_ready = 1'b0;
        i_valid = 1'b1;
        i_data = KAT_KEY;
        repeat (5) @(negedge i_clk);
        check("nokey_idle", {o_busy, o_ready}, 2'b00);

        // Raising key-ready accepts on that cycle; encrypt known answer
        i_key_ready = 1'b1;
        do_block(KAT_KEY, 1'b0, 0, 1'b0, dout, lat, wait_n, pulses, stable);
        check("kat_enc_accept_wait", wait_n, 0);
        check("kat_enc_latency", lat, 193);
        check("kat_enc_data", dout, KAT_CT);
        check("kat_enc_pulses", pulses, 32);
        check_addrs("kat_enc_addrs", 1'b0);

        // Decrypt known answer while holding the result for 10 cycles
        do_block(KAT_CT, 1'b1, 10, 1'b0, dout, lat, wait_n, pulses, stable);
        check("kat_dec_data", dout, KAT_KEY);
        check("kat_dec_latency", lat, 193);
        check_addrs("kat_dec_addrs", 1'b1);
        check("kat_dec_hold_stable", stable, 1'b1);
        check("kat_dec_pulses", pulses, 32);
        check("kat_dec_idle_after", {o_busy, o_valid}, 2'b00);

        // Randomised blocks, key change midway, key-ready dropped mid-block once
        for (int n = 0; n < 6; n++) begin
            if (n == 3) set_key({$urandom, $urandom, $urandom, $urandom});
            din = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            do_block(din, dec, (n == 4) ? 3 : 0, (n == 2), dout, lat, wait_n, pulses, stable);
            check($sformatf("rand%0d_data", n), dout, sm4_ref(din, dec));
            check($sformatf("rand%0d_latency", n), lat, 193);
            check($sformatf("rand%0d_pulses", n), pulses, 32);
        end

        // Back-to-back blocks with i_ready high
        din = {$urandom, $urandom, $urandom, $urandom};
        do_block(din, 1'b0, 0, 1'b0, dout, lat, wait_n, pulses, stable);
        check("b2b_first_data", dout, sm4_ref(din, 1'b0));
        check("b2b_first_pulses", pulses, 32);
        do_block(dout, 1'b1, 0, 1'b0, dout2, lat, wait_n, pulses, stable);
        check("b2b_second_accept_wait", wait_n, 0);
        check("b2b_second_roundtrip", dout2, din);
        check("b2b_second_pulses", pulses, 32);

        // Reset at round 12, then a stray result strobe
        set_key(KAT_KEY);
        din = {$urandom, $urandom, $urandom, $urandom};
        i_valid = 1'b1; i_data = din; i_mode = 1'b0;
        #1;
        check("midrst_accept_ready", o_ready, 1'b1);
        p0 = pulse_cnt;
        @(negedge i_clk);
        i_valid = 1'b0;
        guard = 0;
        while ((pulse_cnt - p0) < 13 && guard < 300) begin
            @(negedge i_clk);
            guard++;
        end
        check("midrst_reached_round12", (pulse_cnt - p0) >= 13, 1'b1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_o_ready", o_ready, 1'b0);
        check_reset_outs("midrst");
        i_rst = 1'b0;
        #1;
        check("midrst_post_o_ready", o_ready, 1'b1);
        stray_d = {$urandom, $urandom, $urandom, $urandom};
        stray_v = 1'b1;
        @(negedge i_clk);
        stray_v = 1'b0;
        repeat (8) @(negedge i_clk);
        check_reset_outs("stray");
        do_block(din, 1'b0, 0, 1'b0, dout, lat, wait_n, pulses, stable);
        check("after_rst_data", dout, sm4_ref(din, 1'b0));
        check("after_rst_latency", lat, 193);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
